neuron_scheduler: RTL and testbench

Time-multiplexed sequencer for one shared combinational neuron datapath. Holds membrane potential and last-spike state for N_NEURONS virtual neurons plus their per-neuron weight vectors. On each `start` it steps the shared datapath through neurons 0..N_NEURONS-1, one neuron per cycle, and writes back results. It then publishes the spike vector for that timestep. Sits between the top-level I/O wrapper and the single neuron instance.

---
 rtl/neuron_scheduler.sv | 158 +++++++++++++++
 tb/tb_neuron_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_scheduler.sv
// neuron_scheduler: time-multiplexes one shared combinational neuron datapath
// across N_NEURONS virtual neurons. Each accepted start walks neurons
// 0..N_NEURONS-1, one per cycle. Results are written back, and the spike vector
// is published together with a one-cycle done pulse.
// Optional feature macro: SPIKE_COUNT_EN adds per-neuron 8-bit saturating
// spike counters and the cnt_addr / cnt_clear / cnt_data ports.
module neuron_scheduler #(
   parameter int N_NEURONS   = 8,
   parameter int N_STAGE     = 3,
   parameter int N_MEMBRANE  = N_STAGE + 2,
   parameter int N_THRESHOLD = N_MEMBRANE - 1,
   localparam int N_SYN      = 2 ** N_STAGE,
   localparam int ADDR_W     = $clog2(N_NEURONS)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         clear_state,
   input  logic [N_SYN-1:0]             inputs,
   input  logic [2:0]                   shift,
   input  logic [N_THRESHOLD-1:0]       threshold,
   input  logic                         cfg_we,
   input  logic [ADDR_W-1:0]            cfg_addr,
   input  logic [N_SYN-1:0]             cfg_weights,
`ifdef SPIKE_COUNT_EN
   input  logic [ADDR_W-1:0]            cnt_addr,
   input  logic                         cnt_clear,
   output logic [7:0]                   cnt_data,
`endif
   output logic [N_SYN-1:0]             dp_inputs,
   output logic [N_SYN-1:0]             dp_weights,
   output logic [2:0]                   dp_shift,
   output logic [N_THRESHOLD-1:0]       dp_threshold,
   output logic signed [N_MEMBRANE-1:0] dp_last_membrane,
   output logic                         dp_was_spike,
   input  logic signed [N_MEMBRANE-1:0] dp_new_membrane,
   input  logic                         dp_is_spike,
   output logic                         busy,
   output logic                         done,
   output logic [N_NEURONS-1:0]         spikes
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]                   state;
   logic [ADDR_W-1:0]            idx;
   logic [ADDR_W-1:0]            rd_idx;
   logic [N_SYN-1:0]             lat_inputs;
   logic [2:0]                   lat_shift;
   logic [N_THRESHOLD-1:0]       lat_threshold;
   logic [N_NEURONS-1:0]         acc;
   logic [N_NEURONS-1:0]         acc_next;
   logic [N_NEURONS-1:0]         was_spike;
   logic [N_SYN-1:0]             weights  [N_NEURONS];
   logic signed [N_MEMBRANE-1:0] membrane [N_NEURONS];

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   // Outside RUN the datapath sees neuron 0 so its inputs stay stable.
   assign rd_idx           = (state == RUN) ? idx : '0;
   assign dp_inputs        = lat_inputs;
   assign dp_shift         = lat_shift;
   assign dp_threshold     = lat_threshold;
   assign dp_weights       = weights[rd_idx];
   assign dp_last_membrane = membrane[rd_idx];
   assign dp_was_spike     = was_spike[rd_idx];

   // Spike accumulator with the current neuron's bit merged in. The final
   // neuron's bit reaches spikes on the same edge that enters DONE.
   always_comb begin
      acc_next      = acc;
      acc_next[idx] = dp_is_spike;
   end

   // Sequencer: accept start, step idx through every neuron, publish spikes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         idx           <= '0;
         acc           <= '0;
         spikes        <= '0;
         lat_inputs    <= '0;
         lat_shift     <= '0;
         lat_threshold <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  lat_inputs    <= inputs;
                  lat_shift     <= shift;
                  lat_threshold <= threshold;
                  acc           <= '0;
                  idx           <= '0;
                  state         <= RUN;
               end
            end
            RUN: begin
               acc <= acc_next;
               idx <= idx + 1'b1;
               if (idx == ADDR_W'(N_NEURONS - 1)) begin
                  spikes <= acc_next;
                  state  <= DONE;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Per-neuron state: write back datapath results in RUN, bulk clear in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_NEURONS; i++) membrane[i] <= '0;
         was_spike <= '0;
      end else if (state == IDLE && clear_state && !start) begin
         for (int i = 0; i < N_NEURONS; i++) membrane[i] <= '0;
         was_spike <= '0;
      end else if (state == RUN) begin
         membrane[idx]  <= dp_new_membrane;
         was_spike[idx] <= dp_is_spike;
      end
   end

   // Weight store: writable only while idle so a timestep sees coherent weights.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_NEURONS; i++) weights[i] <= '0;
      end else if (!busy && cfg_we) begin
         weights[cfg_addr] <= cfg_weights;
      end
   end

`ifdef SPIKE_COUNT_EN
   logic [7:0] count [N_NEURONS];

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign cnt_data = count[cnt_addr];

   // Spike counters: count spikes seen in RUN, hold at 255, clear only when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_NEURONS; i++) count[i] <= '0;
      end else if (state == IDLE && cnt_clear) begin
         for (int i = 0; i < N_NEURONS; i++) count[i] <= '0;
      end else if (state == RUN && dp_is_spike) begin
         count[idx] <= sat_inc(count[idx]);
      end
   end
`endif

endmodule

// File: tb/tb_neuron_scheduler.sv
// Testbench for neuron_scheduler with the datapath stub
// new = last + 1, is_spike = (new >= threshold).
module tb_neuron_scheduler;
   localparam int NN = 8;
   localparam int NM = 5;

   logic                 clk, rst_n, start, clear_state;
   logic [7:0]           inputs;
   logic [2:0]           shift;
   logic [3:0]           threshold;
   logic                 cfg_we;
   logic [2:0]           cfg_addr;
   logic [7:0]           cfg_weights;
   logic [7:0]           dp_inputs, dp_weights;
   logic [2:0]           dp_shift;
   logic [3:0]           dp_threshold;
   logic signed [NM-1:0] dp_last_membrane, dp_new_membrane;
   logic                 dp_was_spike, dp_is_spike;
   logic                 busy, done;
   logic [7:0]           spikes;
`ifdef SPIKE_COUNT_EN
   logic [2:0]           cnt_addr;
   logic                 cnt_clear;
   logic [7:0]           cnt_data;
`endif

   neuron_scheduler #(.N_NEURONS(NN), .N_STAGE(3)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .clear_state(clear_state),
      .inputs(inputs), .shift(shift), .threshold(threshold),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_weights(cfg_weights),
`ifdef SPIKE_COUNT_EN
      .cnt_addr(cnt_addr), .cnt_clear(cnt_clear), .cnt_data(cnt_data),
`endif
      .dp_inputs(dp_inputs), .dp_weights(dp_weights), .dp_shift(dp_shift),
      .dp_threshold(dp_threshold), .dp_last_membrane(dp_last_membrane),
      .dp_was_spike(dp_was_spike), .dp_new_membrane(dp_new_membrane),
      .dp_is_spike(dp_is_spike), .busy(busy), .done(done), .spikes(spikes)
   );

   // Datapath stub
   always_comb begin
      dp_new_membrane = dp_last_membrane + 5'sd1;
      dp_is_spike     = (int'(dp_new_membrane) >= int'(dp_threshold));
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int edges = 0;
   always @(posedge clk) edges <= edges + 1;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic signed [NM-1:0] m_mem [NN];
   logic                 m_ws  [NN];
   logic [7:0]           m_w   [NN];
   int                   m_cnt [NN];
   logic [7:0]           m_spk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NN; i++) begin
         m_mem[i] = '0; m_ws[i] = 1'b0; m_w[i] = '0; m_cnt[i] = 0;
      end
      m_spk = '0;
   endtask

   task automatic idle_clear();
      clear_state = 1'b1;
      @(negedge clk);
      clear_state = 1'b0;
      for (int i = 0; i < NN; i++) begin m_mem[i] = '0; m_ws[i] = 1'b0; end
   endtask

   task automatic idle_write(input logic [2:0] a, input logic [7:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_weights = d;
      @(negedge clk);
      cfg_we = 1'b0;
      m_w[a] = d;
   endtask

   // One timestep, called and returning just after a negedge in IDLE.
   task automatic do_ts(input logic [7:0] in_v, input logic [2:0] sh, input logic [3:0] thr,
                        input bit clr_ws, input bit cfg_ws, input logic [2:0] ca,
                        input logic [7:0] cd, input bit mid_start, input bit mid_cfg,
                        input logic [7:0] mid_d, output int acc_edge, output int done_edge);
      logic [7:0]           acc;
      logic signed [NM-1:0] nm;
      logic                 sp;
      start = 1'b1; inputs = in_v; shift = sh; threshold = thr; clear_state = clr_ws;
      if (cfg_ws) begin
         cfg_we = 1'b1; cfg_addr = ca; cfg_weights = cd; m_w[ca] = cd;
      end
      @(negedge clk);
      acc_edge = edges;
      start = 1'b0; clear_state = 1'b0; cfg_we = 1'b0;
      inputs = 8'($urandom); shift = 3'($urandom); threshold = 4'($urandom);
      acc = '0;
      for (int c = 0; c < NN; c++) begin
         chk($sformatf("busy_run[%0d]", c), busy, 1);
         chk($sformatf("done_run[%0d]", c), done, 0);
         chk($sformatf("dp_inputs[%0d]", c), dp_inputs, in_v);
         chk($sformatf("dp_shift[%0d]", c), dp_shift, sh);
         chk($sformatf("dp_threshold[%0d]", c), dp_threshold, thr);
         chk($sformatf("dp_weights[%0d]", c), dp_weights, m_w[c]);
         chk($sformatf("dp_last_membrane[%0d]", c), dp_last_membrane, m_mem[c]);
         chk($sformatf("dp_was_spike[%0d]", c), dp_was_spike, m_ws[c]);
         nm = m_mem[c] + 5'sd1;
         sp = (int'(nm) >= int'(thr));
         m_mem[c] = nm; m_ws[c] = sp; acc[c] = sp;
         if (sp && m_cnt[c] < 255) m_cnt[c]++;
         start = (mid_start && c == 3);
         if (mid_cfg && c == 2) begin
            cfg_we = 1'b1; cfg_addr = ca; cfg_weights = mid_d;
         end else cfg_we = 1'b0;
         @(negedge clk);
      end
      start = 1'b0; cfg_we = 1'b0;
      chk("done_pulse", done, 1);
      chk("busy_done", busy, 1);
      chk("spikes_at_done", spikes, acc);
      done_edge = done ? edges : -1;
      m_spk = acc;
      @(negedge clk);
      chk("done_after", done, 0);
      chk("busy_after", busy, 0);
      chk("spikes_hold", spikes, m_spk);
   endtask

   typedef struct {
      bit         clr;
      bit         clr_with_start;
      logic [3:0] thr;
      logic [4:0] exp_lm;
      logic       exp_ws;
      logic [7:0] exp_spk;
   } vec_t;

   vec_t tbl [8];
   int   ae, de, first_ae, dcount;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; clear_state = 1'b0; inputs = '0; shift = '0;
      threshold = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_weights = '0;
`ifdef SPIKE_COUNT_EN
      cnt_addr = '0; cnt_clear = 1'b0;
`endif
      model_reset();

      tbl[0] = '{0, 0, 4'd3,  5'd0, 0, 8'h00};
      tbl[1] = '{0, 0, 4'd3,  5'd1, 0, 8'h00};
      tbl[2] = '{0, 0, 4'd3,  5'd2, 0, 8'hFF};
      tbl[3] = '{0, 0, 4'd3,  5'd3, 1, 8'hFF};
      tbl[4] = '{1, 0, 4'd1,  5'd0, 0, 8'hFF};
      tbl[5] = '{0, 0, 4'd4,  5'd1, 1, 8'h00};
      tbl[6] = '{0, 0, 4'd15, 5'd2, 0, 8'h00};
      tbl[7] = '{0, 1, 4'd4,  5'd3, 0, 8'hFF};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_spikes", spikes, 0);
      chk("rst_membrane0", dp_last_membrane, 0);
      chk("rst_weights0", dp_weights, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", busy, 0);

      // Table-driven timesteps; the first three run back to back
      first_ae = 0;
      for (int r = 0; r < 8; r++) begin
         if (tbl[r].clr) idle_clear();
         chk($sformatf("tbl%0d_idle_membrane0", r), dp_last_membrane, 32'(signed'(tbl[r].exp_lm)));
         chk($sformatf("tbl%0d_idle_was_spike0", r), dp_was_spike, tbl[r].exp_ws);
         do_ts(8'h5A, 3'd2, tbl[r].thr, tbl[r].clr_with_start, 0, 0, 0, 0, 0, 0, ae, de);
         if (r == 0) first_ae = ae;
         if (r < 3) chk($sformatf("tbl%0d_done_cycle", r), de - first_ae + 1, 9 + 10 * r);
         chk($sformatf("tbl%0d_spikes", r), spikes, tbl[r].exp_spk);
      end

      // Weight write in IDLE, then start and weight write attempted mid-run
      for (int i = 0; i < NN; i++) idle_write(3'(i), 8'(i * 16 + 3));
      idle_write(3'd5, 8'hA5);
      do_ts(8'hC3, 3'd5, 4'd7, 0, 0, 3'd5, 0, 1, 1, 8'h3C, ae, de);
      dcount = 0;
      repeat (5) begin @(negedge clk); if (done || busy) dcount++; end
      chk("no_restart_after_mid_start", dcount, 0);
      do_ts(8'h0F, 3'd1, 4'd9, 0, 0, 0, 0, 0, 0, 0, ae, de);

      // Weight write in the same cycle as start takes effect immediately
      do_ts(8'hF0, 3'd3, 4'd2, 0, 1, 3'd2, 8'h77, 0, 0, 0, ae, de);

      // Reset mid-run at idx 3
      idle_clear();
      do_ts(8'h11, 3'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0, ae, de);
      chk("spikes_before_abort", spikes, 8'hFF);
      start = 1'b1; threshold = 4'd2;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_spikes", spikes, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      dcount = 0;
      repeat (12) begin @(negedge clk); if (done) dcount++; end
      chk("no_done_after_abort", dcount, 0);
      do_ts(8'h22, 3'd4, 4'd5, 0, 0, 0, 0, 0, 0, 0, ae, de);

      // Randomized timesteps against the model
      for (int t = 0; t < 40; t++) begin
         case ($urandom_range(0, 3))
            0: idle_write(3'($urandom), 8'($urandom));
            1: idle_clear();
            default: ;
         endcase
         repeat ($urandom_range(0, 2)) @(negedge clk);
         do_ts(8'($urandom), 3'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
               3'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), ae, de);
      end

`ifdef SPIKE_COUNT_EN
      for (int a = 0; a < NN; a++) begin
         cnt_addr = 3'(a); #1;
         chk($sformatf("cnt_model[%0d]", a), cnt_data, m_cnt[a]);
      end
      cnt_clear = 1'b1; @(negedge clk); cnt_clear = 1'b0;
      for (int a = 0; a < NN; a++) m_cnt[a] = 0;
      for (int t = 0; t < 300; t++) begin
         idle_clear();
         do_ts(8'h00, 3'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0, ae, de);
      end
      for (int a = 0; a < NN; a++) begin
         cnt_addr = 3'(a); #1;
         chk($sformatf("cnt_sat[%0d]", a), cnt_data, 255);
      end
      cnt_clear = 1'b1; @(negedge clk); cnt_clear = 1'b0;
      for (int a = 0; a < NN; a++) begin
         cnt_addr = 3'(a); #1;
         chk($sformatf("cnt_cleared[%0d]", a), cnt_data, 0);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
